reg_file_8x8: RTL and testbench
===============================

REG_FILE_8X8 -- requirements
Module: reg_file_8x8

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register and data width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (2**ADDR_W = 8 registers).
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port WRITEDATA  input  8  data to write.
REQ-006 SHALL have port WRITEREG  input  3  write address.
REQ-007 SHALL have port WRITEENABLE  input  1  write strobe, sampled at rising CLK.
REQ-008 SHALL have port CLEAR  input  1  synchronous clear of all registers and flags.
REQ-009 SHALL have port BYPASS_EN  input  1  enables same-cycle write-to-read forwarding.
REQ-010 SHALL have port READREG1 / READREG2  input  3 each  read addresses, operand 1 and operand 2.
REQ-011 SHALL have port REGOUT1 / REGOUT2  output  8 each  read data, operand 1 and operand 2 to ALU data1/data2.
REQ-012 SHALL have port VALID1 / VALID2  output  1 each  addressed register written since last reset/clear.
REQ-013 SHALL have port WRCOUNT  output  8  saturating count of committed writes.

Function
REQ-014 Storage SHALL be 8 registers x 8 bits plus an 8-bit written-flag vector.
REQ-015 Reads SHALL be combinational: REGOUTn = reg[READREGn], VALIDn = flag[READREGn], updated same cycle the address changes.
REQ-016 Write SHALL commit at rising CLK when RESET=1, WRITEENABLE=1, CLEAR=0: reg[WRITEREG] <= WRITEDATA, flag[WRITEREG] <= 1, WRCOUNT increments.
REQ-017 WRCOUNT SHALL saturate at 8'hFF and never wrap to 0.
REQ-018 With BYPASS_EN=1, WRITEENABLE=1, CLEAR=0 and READREGn==WRITEREG, REGOUTn SHALL equal WRITEDATA and VALIDn SHALL be 1 in the same cycle, before the edge.
REQ-019 With BYPASS_EN=0, REGOUTn SHALL show the old register value until the edge, then the new value.
REQ-020 READREG1==READREG2 SHALL return identical data on both ports, including under bypass.
REQ-021 CLEAR=1 at rising CLK SHALL zero all registers, all flags and WRCOUNT; CLEAR SHALL take priority over a simultaneous write, and the write SHALL be dropped, not counted.
REQ-022 CLEAR=1 SHALL suppress bypass in that cycle.
REQ-023 WRITEENABLE=0 SHALL leave all state unchanged regardless of WRITEDATA/WRITEREG.
REQ-024 Back-to-back writes to the same register on consecutive edges SHALL each commit; the last one wins, and each is counted.

Reset
REQ-025 RESET=0 SHALL immediately, without waiting for CLK, force all registers to 8'h00, all flags to 0 and WRCOUNT to 8'h00; REGOUTn SHALL read 8'h00 and VALIDn SHALL read 0.
REQ-026 While RESET=0, writes and CLEAR SHALL be ignored, and bypass SHALL be disabled.
REQ-027 Reset asserted mid-cycle, with a write pending, SHALL discard that write.
REQ-028 Reset release SHALL be synchronous-safe: the first write SHALL commit on the first rising edge after RESET rises.

Verification
REQ-029 Reset then read all 8 addresses -> REGOUT1=REGOUT2=8'h00, VALID=0, WRCOUNT=0.
REQ-030 Write 8'h5A to r3, then 8'hC3 to r7, then read r3/r7 -> REGOUT1=8'h5A, REGOUT2=8'hC3, both VALID=1, WRCOUNT=2.
REQ-031 BYPASS_EN=1, write 8'h11 to r2 while READREG1=2 -> REGOUT1=8'h11 before the edge; repeat with BYPASS_EN=0 -> old value until the edge.
REQ-032 CLEAR=1 with a simultaneous write of 8'hFF to r1 -> after the edge r1=8'h00, VALID=0, WRCOUNT=0.
REQ-033 Perform 300 writes -> WRCOUNT=8'hFF held.
REQ-034 Assert RESET=0 between edges after writing r4=8'h9C -> REGOUT of r4 becomes 8'h00 immediately, and the pending write is discarded.

Source files
------------

// File: rtl/reg_file_8x8_if.sv
// Register-file bus: write port, two read ports, validity flags and write counter.
interface reg_file_8x8_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [DATA_W-1:0] WRITEDATA;
    logic [ADDR_W-1:0] WRITEREG;
    logic              WRITEENABLE;
    logic              CLEAR;
    logic              BYPASS_EN;
    logic [ADDR_W-1:0] READREG1;
    logic [ADDR_W-1:0] READREG2;
    logic [DATA_W-1:0] REGOUT1;
    logic [DATA_W-1:0] REGOUT2;
    logic              VALID1;
    logic              VALID2;
    logic [7:0]        WRCOUNT;

    modport master (
        output WRITEDATA, WRITEREG, WRITEENABLE, CLEAR, BYPASS_EN,
        output READREG1, READREG2,
        input  REGOUT1, REGOUT2, VALID1, VALID2, WRCOUNT
    );

    modport slave (
        input  WRITEDATA, WRITEREG, WRITEENABLE, CLEAR, BYPASS_EN,
        input  READREG1, READREG2,
        output REGOUT1, REGOUT2, VALID1, VALID2, WRCOUNT
    );
endinterface

// File: rtl/reg_file_8x8.sv
// 8x8 register file: two combinational read ports with optional write forwarding,
// per-register written flags, saturating write counter, sync clear, async active-low reset.
module reg_file_8x8 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input logic           CLK,
    input logic           RESET,
    reg_file_8x8_if.slave bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   flag_q;
    logic [NREG-1:0]   flag_d;
    logic [7:0]        wrcnt_q;
    logic [7:0]        wrcnt_d;

    logic wr_commit;
    logic bypass1;
    logic bypass2;

    // CLEAR wins over a simultaneous write; the write is neither stored nor counted.
    assign wr_commit = bus.WRITEENABLE && !bus.CLEAR;

    always_comb begin
        regs_d  = regs_q;
        flag_d  = flag_q;
        wrcnt_d = wrcnt_q;
        if (bus.CLEAR) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
            flag_d  = '0;
            wrcnt_d = '0;
        end else if (bus.WRITEENABLE) begin
            regs_d[bus.WRITEREG] = bus.WRITEDATA;
            flag_d[bus.WRITEREG] = 1'b1;
            if (wrcnt_q != 8'hFF) begin
                wrcnt_d = wrcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            flag_q  <= '0;
            wrcnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flag_q  <= flag_d;
            wrcnt_q <= wrcnt_d;
        end
    end

    // Forwarding is gated by RESET so nothing leaks through while the array is held at zero.
    assign bypass1 = RESET && bus.BYPASS_EN && wr_commit && (bus.READREG1 == bus.WRITEREG);
    assign bypass2 = RESET && bus.BYPASS_EN && wr_commit && (bus.READREG2 == bus.WRITEREG);

    assign bus.REGOUT1 = bypass1 ? bus.WRITEDATA : regs_q[bus.READREG1];
    assign bus.REGOUT2 = bypass2 ? bus.WRITEDATA : regs_q[bus.READREG2];
    assign bus.VALID1  = bypass1 | flag_q[bus.READREG1];
    assign bus.VALID2  = bypass2 | flag_q[bus.READREG2];
    assign bus.WRCOUNT = wrcnt_q;
endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed self-checking bench for reg_file_8x8.
module tb_reg_file_8x8;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_file_8x8_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    reg_file_8x8 #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.WRITEDATA   = 8'h00;
        bus.WRITEREG    = 3'd0;
        bus.WRITEENABLE = 1'b0;
        bus.CLEAR       = 1'b0;
        bus.BYPASS_EN   = 1'b0;
        bus.READREG1    = 3'd0;
        bus.READREG2    = 3'd0;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.WRITEREG    = addr;
        bus.WRITEDATA   = data;
        bus.WRITEENABLE = 1'b1;
        @(posedge clk);
        #1;
        bus.WRITEENABLE = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.CLEAR = 1'b1;
        @(posedge clk);
        #1;
        bus.CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.READREG1 = 3'(i);
            bus.READREG2 = 3'(7 - i);
            #1;
            checks++;
            if (bus.REGOUT1 !== 8'h00 || bus.REGOUT2 !== 8'h00) begin
                errors++;
                $display("FAIL reset_data addr %0d: got %h/%h want 00/00", i, bus.REGOUT1, bus.REGOUT2);
            end
            checks++;
            if (bus.VALID1 !== 1'b0 || bus.VALID2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid addr %0d: got %b/%b want 0/0", i, bus.VALID1, bus.VALID2);
            end
        end
        checks++;
        if (bus.WRCOUNT !== 8'h00) begin
            errors++;
            $display("FAIL reset_wrcount: got %h want 00", bus.WRCOUNT);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(3'd3, 8'h5A);
        do_write(3'd7, 8'hC3);
        bus.READREG1 = 3'd3;
        bus.READREG2 = 3'd7;
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h5A || bus.REGOUT2 !== 8'hC3) begin
            errors++;
            $display("FAIL write_read_data: got %h/%h want 5a/c3", bus.REGOUT1, bus.REGOUT2);
        end
        checks++;
        if (bus.VALID1 !== 1'b1 || bus.VALID2 !== 1'b1) begin
            errors++;
            $display("FAIL write_read_valid: got %b/%b want 1/1", bus.VALID1, bus.VALID2);
        end
        checks++;
        if (bus.WRCOUNT !== 8'd2) begin
            errors++;
            $display("FAIL write_read_wrcount: got %h want 02", bus.WRCOUNT);
        end
        bus.READREG1 = 3'd0;
        #1;
        checks++;
        if (bus.VALID1 !== 1'b0 || bus.REGOUT1 !== 8'h00) begin
            errors++;
            $display("FAIL unwritten_r0: got %h valid %b want 00 valid 0", bus.REGOUT1, bus.VALID1);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus.BYPASS_EN   = 1'b1;
        bus.READREG1    = 3'd2;
        bus.READREG2    = 3'd2;
        bus.WRITEREG    = 3'd2;
        bus.WRITEDATA   = 8'h11;
        bus.WRITEENABLE = 1'b1;
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h11 || bus.REGOUT2 !== 8'h11) begin
            errors++;
            $display("FAIL bypass_fwd: got %h/%h want 11/11", bus.REGOUT1, bus.REGOUT2);
        end
        checks++;
        if (bus.VALID1 !== 1'b1 || bus.VALID2 !== 1'b1) begin
            errors++;
            $display("FAIL bypass_valid: got %b/%b want 1/1", bus.VALID1, bus.VALID2);
        end
        @(posedge clk);
        #1;
        bus.WRITEENABLE = 1'b0;
        bus.BYPASS_EN   = 1'b0;
        @(negedge clk);
        bus.WRITEDATA   = 8'h22;
        bus.WRITEENABLE = 1'b1;
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h11) begin
            errors++;
            $display("FAIL nobypass_before_edge: got %h want 11", bus.REGOUT1);
        end
        @(posedge clk);
        #1;
        bus.WRITEENABLE = 1'b0;
        checks++;
        if (bus.REGOUT1 !== 8'h22 || bus.REGOUT2 !== 8'h22) begin
            errors++;
            $display("FAIL nobypass_after_edge: got %h/%h want 22/22", bus.REGOUT1, bus.REGOUT2);
        end
        checks++;
        if (bus.WRCOUNT !== 8'd4) begin
            errors++;
            $display("FAIL bypass_wrcount: got %h want 04", bus.WRCOUNT);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        bus.BYPASS_EN   = 1'b1;
        bus.CLEAR       = 1'b1;
        bus.WRITEREG    = 3'd1;
        bus.WRITEDATA   = 8'hFF;
        bus.WRITEENABLE = 1'b1;
        bus.READREG1    = 3'd1;
        bus.READREG2    = 3'd3;
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h00 || bus.VALID1 !== 1'b0) begin
            errors++;
            $display("FAIL clear_bypass_suppressed: got %h valid %b want 00 valid 0", bus.REGOUT1, bus.VALID1);
        end
        @(posedge clk);
        #1;
        bus.CLEAR       = 1'b0;
        bus.WRITEENABLE = 1'b0;
        bus.BYPASS_EN   = 1'b0;
        checks++;
        if (bus.REGOUT1 !== 8'h00 || bus.VALID1 !== 1'b0) begin
            errors++;
            $display("FAIL clear_r1: got %h valid %b want 00 valid 0", bus.REGOUT1, bus.VALID1);
        end
        checks++;
        if (bus.REGOUT2 !== 8'h00 || bus.VALID2 !== 1'b0) begin
            errors++;
            $display("FAIL clear_r3: got %h valid %b want 00 valid 0", bus.REGOUT2, bus.VALID2);
        end
        checks++;
        if (bus.WRCOUNT !== 8'h00) begin
            errors++;
            $display("FAIL clear_wrcount: got %h want 00", bus.WRCOUNT);
        end
    endtask

    task automatic test_we_low();
        do_write(3'd5, 8'hA5);
        @(negedge clk);
        bus.WRITEREG  = 3'd5;
        bus.WRITEDATA = 8'h3C;
        bus.READREG1  = 3'd5;
        bus.READREG2  = 3'd6;
        @(posedge clk);
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'hA5 || bus.VALID2 !== 1'b0) begin
            errors++;
            $display("FAIL we_low_hold: got %h valid2 %b want a5 valid2 0", bus.REGOUT1, bus.VALID2);
        end
        checks++;
        if (bus.WRCOUNT !== 8'd1) begin
            errors++;
            $display("FAIL we_low_wrcount: got %h want 01", bus.WRCOUNT);
        end
    endtask

    task automatic test_back_to_back();
        do_write(3'd6, 8'h01);
        do_write(3'd6, 8'h02);
        bus.READREG2 = 3'd6;
        #1;
        checks++;
        if (bus.REGOUT2 !== 8'h02 || bus.VALID2 !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_data: got %h valid %b want 02 valid 1", bus.REGOUT2, bus.VALID2);
        end
        checks++;
        if (bus.WRCOUNT !== 8'd3) begin
            errors++;
            $display("FAIL back_to_back_wrcount: got %h want 03", bus.WRCOUNT);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int n = 1; n <= 300; n++) begin
            do_write(3'(n % 8), 8'(n));
            if (n == 254) begin
                checks++;
                if (bus.WRCOUNT !== 8'hFE) begin
                    errors++;
                    $display("FAIL sat_254: got %h want fe", bus.WRCOUNT);
                end
            end
            if (n == 255 || n == 256) begin
                checks++;
                if (bus.WRCOUNT !== 8'hFF) begin
                    errors++;
                    $display("FAIL sat_%0d: got %h want ff", n, bus.WRCOUNT);
                end
            end
        end
        checks++;
        if (bus.WRCOUNT !== 8'hFF) begin
            errors++;
            $display("FAIL sat_300: got %h want ff", bus.WRCOUNT);
        end
        bus.READREG1 = 3'd4;
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h2C) begin
            errors++;
            $display("FAIL sat_last_r4: got %h want 2c", bus.REGOUT1);
        end
    endtask

    task automatic test_reset_midcycle();
        do_clear();
        do_write(3'd4, 8'h9C);
        bus.READREG1 = 3'd4;
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h9C || bus.WRCOUNT !== 8'd1) begin
            errors++;
            $display("FAIL midreset_pre: got %h cnt %h want 9c cnt 01", bus.REGOUT1, bus.WRCOUNT);
        end
        @(negedge clk);
        bus.WRITEREG    = 3'd4;
        bus.WRITEDATA   = 8'h77;
        bus.WRITEENABLE = 1'b1;
        bus.BYPASS_EN   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h00 || bus.VALID1 !== 1'b0 || bus.WRCOUNT !== 8'h00) begin
            errors++;
            $display("FAIL midreset_immediate: got %h valid %b cnt %h want 00 valid 0 cnt 00",
                     bus.REGOUT1, bus.VALID1, bus.WRCOUNT);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.REGOUT1 !== 8'h00 || bus.VALID1 !== 1'b0 || bus.WRCOUNT !== 8'h00) begin
            errors++;
            $display("FAIL midreset_write_dropped: got %h valid %b cnt %h want 00 valid 0 cnt 00",
                     bus.REGOUT1, bus.VALID1, bus.WRCOUNT);
        end
        @(negedge clk);
        bus.BYPASS_EN = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.WRITEENABLE = 1'b0;
        checks++;
        if (bus.REGOUT1 !== 8'h77 || bus.VALID1 !== 1'b1 || bus.WRCOUNT !== 8'd1) begin
            errors++;
            $display("FAIL release_first_write: got %h valid %b cnt %h want 77 valid 1 cnt 01",
                     bus.REGOUT1, bus.VALID1, bus.WRCOUNT);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_we_low();
        test_back_to_back();
        test_saturation();
        test_reset_midcycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
